rst_seq_gen: RTL and testbench

Reset sequencer that drives the active-low reset inputs of downstream FIFO-path blocks in a fixed release order. After a system reset, and again on a software reset request, it holds all stage resets asserted for a programmable time, then releases them one at a time with a programmable gap. It sits between the board reset and the FIFO write-side, storage and read-side logic, so those blocks leave reset in a deterministic order on the shared clock.

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_seq_timer.sv | 24 ++
 rtl/rst_seq_gen.sv | 119 +++++++++++
 tb/tb_rst_seq_gen.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the FIFO-path reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_GAP  = 2'd1,
    S_IDLE = 2'd2,
    S_ACK  = 2'd3
  } rst_seq_state_t;

  // Counter must hold the larger of the two reload values without wrapping.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

  localparam int CNT_W = cnt_width(16, 4);

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter; saturates at zero and flags expiry while at zero.
module rst_seq_timer
  import rst_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLK,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         expired
);

  always_ff @(posedge CLK) begin
    if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rst_seq_gen.sv
// Releases active-low stage resets in index order after a hold time, one per gap,
// restarted by RST or by a four-phase software request on SW_REQ/SW_ACK.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_REQ,
  output logic                SW_ACK,
  output logic [N_STAGES-1:0] STAGE_RST,
  output logic                BUSY,
  output logic [1:0]          DBG_STATE
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);

  rst_seq_state_t state;
  logic [IW-1:0]  idx;
  logic           sw_flag;
  logic           tmr_load;
  logic [CW-1:0]  tmr_val;
  logic [CW-1:0]  cnt;
  logic           expired;
  logic           last_rel;

  rst_seq_timer #(.W(CW)) u_timer (
    .CLK      (CLK),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (cnt),
    .expired  (expired)
  );

  // The release that completes the whole sequence.
  assign last_rel = expired &&
                    (((state == S_HOLD) && (N_STAGES == 1)) ||
                     ((state == S_GAP) && (idx == LAST_IDX)));

  // Reload on every entry into a timed interval; RST doubles as the reset load.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;
    if (RST) begin
      tmr_load = 1'b1;
    end else begin
      case (state)
        S_HOLD: if (expired && !last_rel) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
        S_GAP: if (expired && !last_rel) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
        S_IDLE: if (SW_REQ) tmr_load = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_HOLD;
      STAGE_RST <= '0;
      BUSY      <= 1'b1;
      SW_ACK    <= 1'b0;
      idx       <= '0;
      sw_flag   <= 1'b0;
    end else begin
      case (state)
        S_HOLD: if (expired) begin
          STAGE_RST[0] <= 1'b1;
          idx          <= IW'(1);
          state        <= S_GAP;
        end
        S_GAP: if (expired) begin
          STAGE_RST[idx] <= 1'b1;
          idx            <= idx + 1'b1;
        end
        S_IDLE: if (SW_REQ) begin
          STAGE_RST <= '0;
          BUSY      <= 1'b1;
          sw_flag   <= 1'b1;
          idx       <= '0;
          state     <= S_HOLD;
        end
        S_ACK: if (!SW_REQ) begin
          SW_ACK  <= 1'b0;
          BUSY    <= 1'b0;
          sw_flag <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_HOLD;
      endcase
      // Completion overrides the stage-advance assignments above.
      if (last_rel) begin
        idx <= '0;
        if (sw_flag) begin
          state  <= S_ACK;
          SW_ACK <= 1'b1;
        end else begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      end
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default build plus a single-stage, 1-cycle build.
module tb_rst_seq_gen;
  import rst_seq_pkg::*;

  logic       CLK;
  logic       RST;
  logic       SW_REQ;
  logic       sw_ack_a, busy_a;
  logic [2:0] stage_a;
  logic [1:0] st_a;
  logic       sw_ack_b, busy_b;
  logic [0:0] stage_b;
  logic [1:0] st_b;

  int n_checks = 0;
  int n_errors = 0;

  rst_seq_gen dut_a (
    .CLK(CLK), .RST(RST), .SW_REQ(SW_REQ), .SW_ACK(sw_ack_a),
    .STAGE_RST(stage_a), .BUSY(busy_a), .DBG_STATE(st_a)
  );

  rst_seq_gen #(.N_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .CLK(CLK), .RST(RST), .SW_REQ(SW_REQ), .SW_ACK(sw_ack_b),
    .STAGE_RST(stage_b), .BUSY(busy_b), .DBG_STATE(st_b)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] stg, input logic bsy, input logic ack);
    check({tag, ".stage"}, 32'(stage_a), 32'(stg));
    check({tag, ".busy"},  32'(busy_a),  32'(bsy));
    check({tag, ".ack"},   32'(sw_ack_a), 32'(ack));
  endtask

  initial begin
    RST    = 1'b1;
    SW_REQ = 1'b0;

    // 1: RST sequence, E = third RST edge
    step(3);
    check_a("rst", 3'b000, 1'b1, 1'b0);
    check("rst.state", 32'(st_a), 32'(S_HOLD));
    RST = 1'b0;
    step(15); check_a("hold_e15", 3'b000, 1'b1, 1'b0);
    step(1);  check_a("rel0_e16", 3'b001, 1'b1, 1'b0);
    step(3);  check_a("gap_e19",  3'b001, 1'b1, 1'b0);
    step(1);  check_a("rel1_e20", 3'b011, 1'b1, 1'b0);
    step(3);  check_a("gap_e23",  3'b011, 1'b1, 1'b0);
    step(1);  check_a("rel2_e24", 3'b111, 1'b0, 1'b0);
    check("idle.state", 32'(st_a), 32'(S_IDLE));

    // 2: software request accepted at S
    SW_REQ = 1'b1;
    step(1);  check_a("sw_s", 3'b000, 1'b1, 1'b0);
    step(15); check_a("sw_s15", 3'b000, 1'b1, 1'b0);
    step(1);  check_a("sw_s16", 3'b001, 1'b1, 1'b0);
    step(4);  check_a("sw_s20", 3'b011, 1'b1, 1'b0);
    step(3);  check_a("sw_s23", 3'b011, 1'b1, 1'b0);
    step(1);  check_a("sw_s24", 3'b111, 1'b1, 1'b1);
    step(4);  check_a("sw_hold_ack", 3'b111, 1'b1, 1'b1);
    SW_REQ = 1'b0;
    step(1);  check_a("sw_drop", 3'b111, 1'b0, 1'b0);
    check("sw_drop.state", 32'(st_a), 32'(S_IDLE));

    // 3: SW_REQ pulse mid-gap is ignored and not queued
    RST = 1'b1; step(1); RST = 1'b0;
    step(18); check_a("pg_e18", 3'b001, 1'b1, 1'b0);
    SW_REQ = 1'b1; step(1); SW_REQ = 1'b0;
    step(1);  check_a("pg_e20", 3'b011, 1'b1, 1'b0);
    step(4);  check_a("pg_e24", 3'b111, 1'b0, 1'b0);
    step(2);  check_a("pg_noq", 3'b111, 1'b0, 1'b0);

    // 4: SW_REQ held through an RST sequence starts a new one on first idle edge
    RST = 1'b1; SW_REQ = 1'b1; step(1); RST = 1'b0;
    step(24); check_a("held_e24", 3'b111, 1'b0, 1'b0);
    step(1);  check_a("held_e25", 3'b000, 1'b1, 1'b0);
    step(23); check_a("held_e48", 3'b011, 1'b1, 1'b0);
    step(1);  check_a("held_e49", 3'b111, 1'b1, 1'b1);
    SW_REQ = 1'b0;
    step(1);  check_a("held_drop", 3'b111, 1'b0, 1'b0);

    // 5: RST at E+18, after stage 0 released
    RST = 1'b1; step(1); RST = 1'b0;
    step(17); check_a("mid_e17", 3'b001, 1'b1, 1'b0);
    RST = 1'b1; step(1); RST = 1'b0;
    check_a("mid_rst", 3'b000, 1'b1, 1'b0);
    step(15); check_a("mid_n15", 3'b000, 1'b1, 1'b0);
    step(1);  check_a("mid_n16", 3'b001, 1'b1, 1'b0);
    step(8);  check_a("mid_n24", 3'b111, 1'b0, 1'b0);

    // RST while acknowledging drops the handshake
    SW_REQ = 1'b1;
    step(25); check_a("ack_pre", 3'b111, 1'b1, 1'b1);
    RST = 1'b1; SW_REQ = 1'b0; step(1); RST = 1'b0;
    check_a("ack_rst", 3'b000, 1'b1, 1'b0);
    check("b.rst.stage", 32'(stage_b), 32'd0);
    check("b.rst.busy",  32'(busy_b),  32'd1);

    // 6: single-stage, HOLD=1 build
    step(1);
    check("b.e1.stage", 32'(stage_b), 32'd1);
    check("b.e1.busy",  32'(busy_b),  32'd0);
    check("b.e1.state", 32'(st_b),    32'(S_IDLE));
    check("a.e1.stage", 32'(stage_a), 32'd0);
    SW_REQ = 1'b1;
    step(1);
    check("b.s.stage", 32'(stage_b), 32'd0);
    check("b.s.busy",  32'(busy_b),  32'd1);
    step(1);
    check("b.s1.stage", 32'(stage_b), 32'd1);
    check("b.s1.ack",   32'(sw_ack_b), 32'd1);
    check("b.s1.busy",  32'(busy_b),  32'd1);
    SW_REQ = 1'b0;
    step(1);
    check("b.drop.ack",  32'(sw_ack_b), 32'd0);
    check("b.drop.busy", 32'(busy_b),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
